// File: rtl/dlx_ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : dlx_ifetch_buffer
// Description : Sequential instruction prefetch FIFO between the instruction
//               ROM and the DLX core, with redirect flush and stale-response drop.
// Revision    : 1.0 - initial release
// ============================================================================
module dlx_ifetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic        cpu_valid,
    output logic [31:0] cpu_data,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic        rom_valid,
    input  logic [31:0] rom_data
);

    localparam int            c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_BUSY  = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [31:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [31:0]     r_fetch_pc;
    logic [1:0]      r_state;
    logic            r_rom_req;
    logic [31:0]     r_rom_addr;

    logic            w_nonempty;
    logic [31:0]     w_head_pc;
    logic [31:0]     w_expected;
    logic            w_hit;
    logic            w_redirect;
    logic            w_push;
    logic            w_pop;
    logic [c_AW:0]   w_count_next;
    logic [1:0]      w_state_settled;
    logic            w_issue;

    assign w_nonempty = (r_count != '0);
    assign w_head_pc  = r_pc_mem[r_rd_ptr];

    // Address the core should ask for next if it is still following the stream
    assign w_expected = w_nonempty          ? w_head_pc  :
                        (r_state == c_BUSY) ? r_rom_addr : r_fetch_pc;

    assign w_hit      = cpu_req && w_nonempty && (w_head_pc == cpu_addr);
    assign w_redirect = cpu_req && (cpu_addr != w_expected);
    assign w_push     = rom_valid && (r_state == c_BUSY) && !w_redirect;
    assign w_pop      = w_hit;

    assign w_count_next = w_redirect ? '0
                        : r_count + (c_AW + 1)'(w_push) - (c_AW + 1)'(w_pop);

    // State once the response and redirect of this cycle are accounted for
    always_comb begin
        w_state_settled = r_state;
        if (rom_valid && (r_state != c_IDLE)) begin
            w_state_settled = c_IDLE;
        end else if (w_redirect && (r_state == c_BUSY)) begin
            w_state_settled = c_DRAIN;
        end
    end

    assign w_issue = (w_state_settled == c_IDLE) && !w_redirect && (w_count_next < c_FULL);

    assign cpu_valid = w_hit;
    assign cpu_data  = r_instr_mem[r_rd_ptr];
    assign rom_req   = r_rom_req;
    assign rom_addr  = r_rom_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_state    <= c_IDLE;
            r_rom_req  <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_count   <= w_count_next;
            r_state   <= w_issue ? c_BUSY : w_state_settled;
            r_rom_req <= w_issue;

            if (w_redirect) begin
                r_rd_ptr   <= r_wr_ptr;
                r_fetch_pc <= cpu_addr;
            end else begin
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]    <= r_rom_addr;
                    r_instr_mem[r_wr_ptr] <= rom_data;
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_issue) begin
                    r_rom_addr <= r_fetch_pc;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dlx_ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dlx_ifetch_buffer
// Description : Directed self-checking bench for dlx_ifetch_buffer with a
//               variable-latency ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dlx_ifetch_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_valid;
    logic [31:0] cpu_data;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_valid;
    logic [31:0] rom_data;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          rom_lat  = 1;
    logic        pend     = 1'b0;
    int          rem      = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] req_addr_q[$];
    int          req_cyc_q[$];

    dlx_ifetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_valid (cpu_valid),
        .cpu_data  (cpu_data),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_valid (rom_valid),
        .rom_data  (rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // ROM: answers each request rom_lat cycles later and logs every request
    always @(negedge clk) begin
        rom_valid = 1'b0;
        if (pend) begin
            rem = rem - 1;
            if (rem == 0) begin
                rom_valid = 1'b1;
                rom_data  = rom_word(pend_addr);
                pend      = 1'b0;
            end
        end
        if (rom_req) begin
            pend      = 1'b1;
            rem       = rom_lat;
            pend_addr = rom_addr;
            req_addr_q.push_back(rom_addr);
            req_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input int lat);
        tick();
        reset   = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        tick();
        tick();
        pend      = 1'b0;
        rom_valid = 1'b0;
        rom_lat   = lat;
        req_addr_q.delete();
        req_cyc_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_reqs(input int n);
        int k = 0;
        while (req_addr_q.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk("wait_req", 32'(req_addr_q.size() >= n), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          got;
        logic [31:0] a;

        reset     = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        rom_valid = 1'b0;
        rom_data  = '0;
        #1 reset  = 1'b1;

        // reset values
        tick();
        tick();
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        #1;
        chk("rst_rom_req",   32'(rom_req),   32'd0);
        chk("rst_rom_addr",  rom_addr,       32'h0);
        chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("rst_cpu_data",  cpu_data,       32'h0);

        // stream at ROM latency 1
        do_reset(1);
        c0 = cyc;
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        a = 32'h0;
        got = 0;
        for (int k = 0; k < 60 && got < 6; k++) begin
            tick();
            cpu_req = 1'b1;
            cpu_addr = a;
            #1;
            if (cpu_valid) begin
                chk("stream_data", cpu_data, rom_word(a));
                a = a + 32'd4;
                got++;
            end
        end
        chk("stream_count", 32'(got), 32'd6);
        chk("stream_nreq", 32'(req_addr_q.size() >= 6), 32'd1);
        if (req_cyc_q.size() > 0) chk("startup_cycle", 32'(req_cyc_q[0]), 32'(c0 + 1));
        for (int i = 0; i < 6 && i < req_addr_q.size(); i++) begin
            chk("stream_addr", req_addr_q[i], 32'(4 * i));
            if (i > 0) chk("stream_gap", 32'(req_cyc_q[i] - req_cyc_q[i-1]), 32'd2);
        end

        // full queue, then a pop frees space for 0x10
        do_reset(1);
        repeat (20) tick();
        #1;
        chk("full_nreq", 32'(req_addr_q.size()), 32'd4);
        if (req_addr_q.size() >= 4) chk("full_last_addr", req_addr_q[3], 32'hC);
        chk("full_idle_req", 32'(rom_req), 32'd0);
        tick();
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        #1;
        chk("full_pop_valid", 32'(cpu_valid), 32'd1);
        chk("full_pop_data",  cpu_data, rom_word(32'h0));
        tick();
        cpu_req = 1'b0;
        #1;
        chk("full_refill_req",  32'(rom_req), 32'd1);
        chk("full_refill_addr", rom_addr, 32'h10);

        // redirect from IDLE with a full queue
        do_reset(1);
        repeat (12) tick();
        cpu_req = 1'b1;
        cpu_addr = 32'h40;
        #1;
        chk("rdi_valid", 32'(cpu_valid), 32'd0);
        tick();
        #1;
        chk("rdi_no_req", 32'(rom_req), 32'd0);
        tick();
        #1;
        chk("rdi_req",  32'(rom_req), 32'd1);
        chk("rdi_addr", rom_addr, 32'h40);
        tick();
        tick();
        #1;
        chk("rdi_hit",  32'(cpu_valid), 32'd1);
        chk("rdi_data", cpu_data, rom_word(32'h40));

        // redirect while 0x8 is outstanding, latency 3
        do_reset(3);
        wait_reqs(3);
        cpu_req = 1'b1;
        cpu_addr = 32'h100;
        #1;
        chk("rdb_valid", 32'(cpu_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            #1;
            chk("rdb_wait", 32'(rom_req), 32'd0);
        end
        tick();
        #1;
        chk("rdb_req",  32'(rom_req), 32'd1);
        chk("rdb_addr", rom_addr, 32'h100);
        repeat (4) tick();
        #1;
        chk("rdb_hit",  32'(cpu_valid), 32'd1);
        chk("rdb_data", cpu_data, rom_word(32'h100));

        // redirect in the same cycle as rom_valid
        do_reset(3);
        wait_reqs(1);
        repeat (3) tick();
        cpu_req = 1'b1;
        cpu_addr = 32'h200;
        #1;
        chk("rdv_valid", 32'(cpu_valid), 32'd0);
        tick();
        #1;
        chk("rdv_no_req", 32'(rom_req), 32'd0);
        tick();
        #1;
        chk("rdv_req",  32'(rom_req), 32'd1);
        chk("rdv_addr", rom_addr, 32'h200);
        repeat (4) tick();
        #1;
        chk("rdv_hit",  32'(cpu_valid), 32'd1);
        chk("rdv_data", cpu_data, rom_word(32'h200));

        // async reset while 0x8 is outstanding; its late response must be ignored
        do_reset(3);
        wait_reqs(3);
        tick();
        reset = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        #1;
        chk("arst_rom_req",   32'(rom_req),   32'd0);
        chk("arst_rom_addr",  rom_addr,       32'h0);
        chk("arst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("arst_cpu_data",  cpu_data,       32'h0);
        cpu_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        #1;
        chk("arst_req",  32'(rom_req), 32'd1);
        chk("arst_addr", rom_addr, 32'h0);
        repeat (4) tick();
        cpu_req = 1'b1;
        cpu_addr = 32'h0;
        #1;
        chk("arst_hit",  32'(cpu_valid), 32'd1);
        chk("arst_data", cpu_data, rom_word(32'h0));
        cpu_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
